// File: rtl/wb_cmd_master.sv
// Wishbone initiator: turns single-word upstream commands into single read/write
// bus cycles, with a bus timeout and a valid/ready response channel.
module wb_cmd_master #(
    parameter int                   ADDRWIDTH      = 10,
    parameter int                   DATAWIDTH      = 32,
    parameter int                   TIMEOUT_CYCLES = 16,
    parameter logic [DATAWIDTH-1:0] ERR_DATA       = 32'hBAD0_0ACC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    input  logic [3:0]           cmd_byte_stb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [7:0]           err_cnt_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                 state_q;
    logic [7:0]             tmo_q;
    logic [ADDRWIDTH-1:0]   adr_q;
    logic                   cyc_q;
    logic                   we_q;
    logic [3:0]             bstb_q;
    logic [DATAWIDTH-1:0]   wdat_q;
    logic                   rsp_valid_q;
    logic [DATAWIDTH-1:0]   rsp_dat_q;
    logic                   rsp_err_q;
    logic [7:0]             err_cnt_q;

    assign cmd_ready_o    = (state_q == IDLE);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_dat_o      = rsp_dat_q;
    assign rsp_err_o      = rsp_err_q;
    assign err_cnt_o      = err_cnt_q;
    assign WBm_ADR_o      = adr_q;
    // Single cycles only, so STB is simply a copy of CYC.
    assign WBm_CYC_o      = cyc_q;
    assign WBm_STB_o      = cyc_q;
    assign WBm_WE_o       = we_q;
    assign WBm_BYTE_STB_o = bstb_q;
    assign WBm_DAT_o      = wdat_q;

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            adr_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            bstb_q      <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        adr_q   <= cmd_adr_i;
                        we_q    <= cmd_we_i;
                        bstb_q  <= cmd_byte_stb_i;
                        wdat_q  <= cmd_we_i ? cmd_dat_i : '0;
                        cyc_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    // ACK takes priority over a timeout landing on the same edge.
                    if (WBm_ACK_i) begin
                        cyc_q       <= 1'b0;
                        rsp_dat_q   <= we_q ? '0 : WBm_DAT_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (tmo_q == TMO_LAST) begin
                        cyc_q       <= 1'b0;
                        rsp_dat_q   <= ERR_DATA;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        state_q     <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
